mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single shared memory port of the pipelined core. It serves instruction fetch (I-side) and the MEM-stage load/store (D-side, fed by the EX/MEM pipeline register outputs) over one variable-latency req/ack memory interface. It generates per-access byte enables, store-data lane replication and load sign/zero extension from funct3. It returns a one-cycle ready pulse to each side, which the hazard logic uses to stall the pipeline.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one req/ack memory port between instruction fetch and MEM-stage loads/stores.
// Builds byte enables and replicated store lanes, and sign/zero-extends load data.
module mem_port_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_ready,
   input  logic             mem_read_m,
   input  logic             mem_write_m,
   input  logic [WIDTH-1:0] alu_result_m,
   input  logic [WIDTH-1:0] write_data_m,
   input  logic [2:0]       funct3_m,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata
);

   // state  | meaning
   // IDLE   | no access; D-side wins over I-side on grant
   // I_ACC  | fetch in flight, waiting for mem_ack
   // D_ACC  | load/store in flight, waiting for mem_ack
   // I_RESP | if_ready pulse; requests ignored
   // D_RESP | d_ready pulse; requests ignored
   typedef enum logic [2:0] {
      S_IDLE,
      S_I_ACC,
      S_D_ACC,
      S_I_RESP,
      S_D_RESP
   } state_t;

   state_t           r_state;
   logic [2:0]       r_funct3;
   logic [1:0]       r_lane;
   logic             r_if_ready;
   logic             r_d_ready;
   logic             r_mem_req;
   logic             r_mem_we;
   logic [3:0]       r_mem_be;
   logic [WIDTH-1:0] r_if_rdata;
   logic [WIDTH-1:0] r_d_rdata;
   logic [WIDTH-1:0] r_mem_addr;
   logic [WIDTH-1:0] r_mem_wdata;

   logic [3:0]       w_d_be;
   logic [WIDTH-1:0] w_d_wdata;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [WIDTH-1:0] w_load;
   logic             w_unused_ok;

   // Fetches are always word-aligned, so the low fetch address bits are dropped.
   assign w_unused_ok = ^if_addr[1:0];

   always_comb begin
      w_d_be    = 4'b1111;
      w_d_wdata = write_data_m;
      case (funct3_m[1:0])
         2'b00: begin
            w_d_be    = 4'b0001 << alu_result_m[1:0];
            w_d_wdata = {4{write_data_m[7:0]}};
         end
         2'b01: begin
            w_d_be    = 4'b0011 << {alu_result_m[1], 1'b0};
            w_d_wdata = {2{write_data_m[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_byte = mem_rdata[7:0];
      case (r_lane)
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         2'd3:    w_byte = mem_rdata[31:24];
         default: w_byte = mem_rdata[7:0];
      endcase
      w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_load = mem_rdata;
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b100:  w_load = {24'd0, w_byte};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_funct3    <= 3'd0;
         r_lane      <= 2'd0;
         r_if_ready  <= 1'b0;
         r_d_ready   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'd0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_if_ready <= 1'b0;
         r_d_ready  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mem_read_m || mem_write_m) begin
                  r_state     <= S_D_ACC;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= mem_write_m;
                  r_mem_addr  <= {alu_result_m[WIDTH-1:2], 2'b00};
                  r_mem_wdata <= w_d_wdata;
                  r_mem_be    <= w_d_be;
                  r_funct3    <= funct3_m;
                  r_lane      <= alu_result_m[1:0];
               end else if (if_req) begin
                  r_state     <= S_I_ACC;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= {if_addr[WIDTH-1:2], 2'b00};
                  r_mem_wdata <= '0;
                  r_mem_be    <= 4'b1111;
               end
            end
            S_I_ACC: begin
               if (mem_ack) begin
                  r_state    <= S_I_RESP;
                  r_mem_req  <= 1'b0;
                  r_if_rdata <= mem_rdata;
                  r_if_ready <= 1'b1;
               end
            end
            S_D_ACC: begin
               if (mem_ack) begin
                  r_state   <= S_D_RESP;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_d_rdata <= r_mem_we ? '0 : w_load;
                  r_d_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_rdata  = r_if_rdata;
   assign if_ready  = r_if_ready;
   assign d_rdata   = r_d_rdata;
   assign d_ready   = r_d_ready;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, inline checks against
// hand-computed values. Cycle 0 is the cycle in which a request is first presented.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        mem_read_m;
   logic        mem_write_m;
   logic [31:0] alu_result_m;
   logic [31:0] write_data_m;
   logic [2:0]  funct3_m;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .alu_result_m(alu_result_m),
      .write_data_m(write_data_m), .funct3_m(funct3_m), .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one D-side access; ack arrives lat cycles after mem_req rises.
   task automatic d_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input logic [31:0] rdat, input int lat,
                           output logic [31:0] o_addr, output logic [31:0] o_wdata,
                           output logic [3:0] o_be, output logic o_we, output logic o_req,
                           output logic [31:0] o_rdata, output int o_cyc);
      int c;
      mem_read_m = rd; mem_write_m = wr; alu_result_m = a;
      write_data_m = wd; funct3_m = f3;
      o_cyc = -1; o_rdata = 32'hxxxx_xxxx;
      tick(); c = 1;
      o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we; o_req = mem_req;
      while (c < 30 && o_cyc < 0) begin
         if (c == 1 + lat) begin mem_ack = 1'b1; mem_rdata = rdat; end
         tick(); c++;
         mem_ack = 1'b0; mem_rdata = 32'h0;
         if (d_ready) begin o_cyc = c; o_rdata = d_rdata; end
      end
      mem_read_m = 1'b0; mem_write_m = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({if_ready, d_ready, mem_req, mem_we} !== 4'b0) begin
         errors++; $display("FAIL reset_flags got=%b want=0000", {if_ready, d_ready, mem_req, mem_we});
      end
      checks++;
      if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'd0 || mem_be !== 4'd0) begin
         errors++; $display("FAIL reset_data if_rdata=%h d_rdata=%h addr=%h wdata=%h be=%b want all 0",
                            if_rdata, d_rdata, mem_addr, mem_wdata, mem_be);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lw();
      logic [31:0] a, wd, rd; logic [3:0] be; logic we, rq; int cyc;
      d_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 3'b010, 32'hDEAD_BEEF, 2,
               a, wd, be, we, rq, rd, cyc);
      checks++;
      if (a !== 32'h104 || be !== 4'b1111 || we !== 1'b0 || rq !== 1'b1) begin
         errors++; $display("FAIL lw_request addr=%h be=%b we=%b req=%b want 104/1111/0/1", a, be, we, rq);
      end
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got=%h want=deadbeef", rd); end
      checks++;
      if (cyc !== 4) begin errors++; $display("FAIL lw_latency got=%0d want=4", cyc); end
   endtask

   task automatic test_store();
      logic [31:0] a, wd, rd; logic [3:0] be; logic we, rq; int cyc;
      d_access(1'b0, 1'b1, 32'h0000_0203, 32'h0000_00A5, 3'b000, 32'h1234_5678, 0,
               a, wd, be, we, rq, rd, cyc);
      checks++;
      if (a !== 32'h200 || be !== 4'b1000 || we !== 1'b1 || wd !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL sb_request addr=%h be=%b we=%b wdata=%h want 200/1000/1/a5a5a5a5", a, be, we, wd);
      end
      checks++;
      if (rd !== 32'h0 || cyc !== 2) begin
         errors++; $display("FAIL sb_resp rdata=%h cyc=%0d want 0/2", rd, cyc);
      end
      d_access(1'b0, 1'b1, 32'h0000_0302, 32'hFFFF_1234, 3'b001, 32'h0, 1,
               a, wd, be, we, rq, rd, cyc);
      checks++;
      if (a !== 32'h300 || be !== 4'b1100 || wd !== 32'h1234_1234 || cyc !== 3) begin
         errors++; $display("FAIL sh_request addr=%h be=%b wdata=%h cyc=%0d want 300/1100/12341234/3", a, be, wd, cyc);
      end
      d_access(1'b1, 1'b1, 32'h0000_0107, 32'hCAFE_F00D, 3'b010, 32'h5555_5555, 0,
               a, wd, be, we, rq, rd, cyc);
      checks++;
      if (a !== 32'h104 || be !== 4'b1111 || we !== 1'b1 || wd !== 32'hCAFE_F00D || rd !== 32'h0) begin
         errors++; $display("FAIL rw_misaligned_sw addr=%h be=%b we=%b wdata=%h rdata=%h want 104/1111/1/cafef00d/0",
                            a, be, we, wd, rd);
      end
   endtask

   task automatic test_load_ext();
      logic [31:0] a, wd, rd; logic [3:0] be; logic we, rq; int cyc;
      logic [31:0] addrs [5] = '{32'h13, 32'h23, 32'h32, 32'h40, 32'h51};
      logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
      logic [31:0] exps  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_7F01, 32'h0000_007F};
      logic [3:0]  bes   [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};
      for (int i = 0; i < 5; i++) begin
         d_access(1'b1, 1'b0, addrs[i], 32'h0, f3s[i], 32'h80F0_7F01, 0,
                  a, wd, be, we, rq, rd, cyc);
         checks++;
         if (rd !== exps[i] || be !== bes[i] || cyc !== 2) begin
            errors++; $display("FAIL load_ext[%0d] rdata=%h be=%b cyc=%0d want %h/%b/2", i, rd, be, cyc, exps[i], bes[i]);
         end
      end
   endtask

   task automatic test_priority();
      int d_cyc = -1, i_cyc = -1, rises = 0, both = 0;
      logic prev_req = 1'b0;
      logic [31:0] d_word = 32'h0, i_word = 32'h0, first_addr = 32'h0, i_addr = 32'h0;
      logic        i_seen = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0042;
      mem_read_m = 1'b1; alu_result_m = 32'h0000_0080; funct3_m = 3'b010;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) first_addr = mem_addr;
         if (mem_req && !prev_req) begin
            rises++;
            if (rises == 2 && !i_seen) begin i_addr = mem_addr; i_seen = 1'b1; end
         end
         prev_req = mem_req;
         if (d_ready && if_ready) both++;
         if (d_ready) begin d_cyc = c; d_word = d_rdata; mem_read_m = 1'b0; end
         if (if_ready) begin i_cyc = c; i_word = if_rdata; if_req = 1'b0; end
         mem_ack = mem_req;
         mem_rdata = mem_addr ^ 32'h5A5A_0000;
      end
      mem_ack = 1'b0;
      checks++;
      if (first_addr !== 32'h80 || d_cyc !== 2 || d_word !== 32'h5A5A_0080) begin
         errors++; $display("FAIL prio_d_first addr=%h d_cyc=%0d rdata=%h want 80/2/5a5a0080", first_addr, d_cyc, d_word);
      end
      checks++;
      if (i_addr !== 32'h40 || i_cyc !== 5 || i_word !== 32'h5A5A_0040) begin
         errors++; $display("FAIL prio_i_second addr=%h i_cyc=%0d rdata=%h want 40/5/5a5a0040", i_addr, i_cyc, i_word);
      end
      checks++;
      if (rises !== 2 || both !== 0) begin
         errors++; $display("FAIL prio_counts rises=%0d both_ready=%0d want 2/0", rises, both);
      end
   endtask

   task automatic test_back_to_back();
      int rises = 0, d_pulses = 0, i_pulses = 0, spurious = 0;
      logic prev_req = 1'b0;
      mem_read_m = 1'b1; alu_result_m = 32'h0000_0010; funct3_m = 3'b010;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (mem_req && !prev_req) rises++;
         prev_req = mem_req;
         if (d_ready) d_pulses++;
         if (if_ready) i_pulses++;
         mem_ack = mem_req;
         mem_rdata = 32'h1111_2222;
      end
      mem_ack = 1'b0; mem_read_m = 1'b0;
      tick(); tick();
      checks++;
      if (rises !== 4 || d_pulses !== 4 || i_pulses !== 0) begin
         errors++; $display("FAIL held_req rises=%0d d_pulses=%0d i_pulses=%0d want 4/4/0", rises, d_pulses, i_pulses);
      end
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (d_ready || if_ready || mem_req) spurious++;
      end
      mem_ack = 1'b0;
      checks++;
      if (spurious !== 0) begin errors++; $display("FAIL spurious_ack got=%0d ready/req cycles want=0", spurious); end
   endtask

   task automatic test_rst_in_acc();
      int late_ready = 0, i_cyc = -1;
      logic [31:0] i_word = 32'h0;
      mem_read_m = 1'b1; alu_result_m = 32'h0000_0300; funct3_m = 3'b010;
      tick();
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_acc_setup mem_req=%b want=1", mem_req); end
      rst = 1'b1;
      tick();
      checks++;
      if ({mem_req, mem_we, d_ready, if_ready} !== 4'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || d_rdata !== 32'h0) begin
         errors++; $display("FAIL rst_acc_clear req=%b we=%b d_ready=%b addr=%h be=%b want all 0",
                            mem_req, mem_we, d_ready, mem_addr, mem_be);
      end
      rst = 1'b0; mem_read_m = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
      for (int c = 0; c < 3; c++) begin
         tick();
         mem_ack = 1'b0;
         if (d_ready || mem_req) late_ready++;
      end
      checks++;
      if (late_ready !== 0) begin errors++; $display("FAIL rst_acc_no_ready got=%0d want=0", late_ready); end
      if_req = 1'b1; if_addr = 32'h0000_1003;
      for (int c = 1; c <= 10 && i_cyc < 0; c++) begin
         tick();
         mem_ack = 1'b0;
         if (if_ready) begin i_cyc = c; i_word = if_rdata; if_req = 1'b0; end
         if (c == 2) begin mem_ack = 1'b1; mem_rdata = (mem_addr === 32'h1000) ? 32'h0013_0093 : 32'hBAD0_BAD0; end
      end
      mem_ack = 1'b0; if_req = 1'b0;
      tick();
      checks++;
      if (i_cyc !== 3 || i_word !== 32'h0013_0093) begin
         errors++; $display("FAIL fetch_after_rst cyc=%0d rdata=%h want 3/00130093", i_cyc, i_word);
      end
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
      mem_read_m = 1'b0; mem_write_m = 1'b0; alu_result_m = 32'h0;
      write_data_m = 32'h0; funct3_m = 3'b000; mem_ack = 1'b0; mem_rdata = 32'h0;
      test_reset();
      test_lw();
      test_store();
      test_load_ext();
      test_priority();
      test_back_to_back();
      test_rst_in_acc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
